regfile_wr_arbiter: RTL and testbench

//  Owns the single write port of the 32x64 register file. Clears all entries after

---
 rtl/regfile_pkg.sv | 20 ++
 rtl/rf_init_counter.sv | 37 +++
 rtl/regfile_wr_arbiter.sv | 173 +++++++++++++++++
 tb/tb_regfile_wr_arbiter.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared types for the register-file write-port arbiter: FSM states, grant codes
// and default port widths.
package regfile_pkg;

    localparam int ADDR_W_DEF = 5;
    localparam int DATA_W_DEF = 64;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_WB   = 2'd1,
        GNT_DBG  = 2'd2,
        GNT_INIT = 2'd3
    } gnt_e;

endpackage

// File: rtl/rf_init_counter.sv
// Address sequencer for the regfile clear sweep; one extra count bit lets the
// counter park past the last entry instead of wrapping.
module rf_init_counter
    import regfile_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int NUM_REGS = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_start,
    input  logic              i_en,
    output logic [ADDR_W-1:0] o_addr,
    output logic              o_last
);

    localparam logic [ADDR_W:0] LAST_CNT = (ADDR_W+1)'(NUM_REGS - 1);

    logic [ADDR_W:0] r_cnt;

    // Sweep counter: restart on request, advance while the sweep is active.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_start) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= r_cnt + (ADDR_W+1)'(1);
        end else begin
            r_cnt <= r_cnt;
        end
    end

    assign o_addr = r_cnt[ADDR_W-1:0];
    assign o_last = (r_cnt == LAST_CNT);

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Single write-port owner for the register file: clear sweep after reset/clr_req,
// then writeback-priority arbitration with a starvation guard for the console.
module regfile_wr_arbiter
    import regfile_pkg::*;
#(
    parameter int              ADDR_W       = ADDR_W_DEF,
    parameter int              DATA_W       = DATA_W_DEF,
    parameter int              NUM_REGS     = 32,
    parameter int              STARVE_LIMIT = 4,
    parameter logic [DATA_W-1:0] INIT_VALUE = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr_req,
    input  logic              wb_wena,
    input  logic [ADDR_W-1:0] wb_waddr,
    input  logic [DATA_W-1:0] wb_wdata,
    output logic              wb_stall,
    input  logic              dbg_req,
    input  logic [ADDR_W-1:0] dbg_waddr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic              dbg_ack,
    output logic              rf_wena,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              init_done
);

    localparam int STV_W = $clog2(STARVE_LIMIT + 1);

    state_e            r_state;
    state_e            w_state_nx;
    gnt_e              w_gnt;
    logic              w_clr;
    logic [STV_W-1:0]  r_starve;
    logic [STV_W-1:0]  w_starve_nx;
    logic              w_stall_nx;
    logic              r_wb_stall;
    logic              r_dbg_ack;
    logic              r_rf_wena;
    logic [ADDR_W-1:0] r_rf_waddr;
    logic [DATA_W-1:0] r_rf_wdata;
    logic              r_init_done;
    logic [ADDR_W-1:0] w_init_addr;
    logic              w_init_last;

    rf_init_counter #(
        .ADDR_W   (ADDR_W),
        .NUM_REGS (NUM_REGS)
    ) u_init_counter (
        .clk     (clk),
        .rst     (rst),
        .i_start (w_clr),
        .i_en    (r_state == ST_INIT),
        .o_addr  (w_init_addr),
        .o_last  (w_init_last)
    );

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_INIT;
        end else begin
            r_state <= w_state_nx;
        end
    end

    // Next state, grant selection and starvation bookkeeping.
    always_comb begin
        w_state_nx  = r_state;
        w_gnt       = GNT_NONE;
        w_clr       = 1'b0;
        w_starve_nx = r_starve;
        w_stall_nx  = r_wb_stall;
        case (r_state)
            ST_INIT: begin
                w_gnt = GNT_INIT;
                if (w_init_last) begin
                    w_state_nx = ST_RUN;
                    w_stall_nx = 1'b0;
                end else begin
                    w_state_nx = ST_INIT;
                end
            end
            ST_RUN: begin
                if (clr_req) begin
                    w_clr       = 1'b1;
                    w_state_nx  = ST_INIT;
                    w_starve_nx = '0;
                    w_stall_nx  = 1'b1;
                end else if (r_wb_stall && dbg_req) begin
                    w_gnt = GNT_DBG;
                end else if (wb_wena && !r_wb_stall) begin
                    w_gnt = GNT_WB;
                end else if (dbg_req && !r_dbg_ack) begin
                    w_gnt = GNT_DBG;
                end else begin
                    w_gnt = GNT_NONE;
                end

                // A request still visible during its ack cycle neither counts nor resets.
                if (clr_req) begin
                    w_starve_nx = '0;
                end else if (w_gnt == GNT_DBG) begin
                    w_starve_nx = '0;
                    w_stall_nx  = 1'b0;
                end else if (!dbg_req) begin
                    w_starve_nx = '0;
                end else if (!r_dbg_ack) begin
                    if (r_starve >= STV_W'(STARVE_LIMIT - 1)) begin
                        w_starve_nx = STV_W'(STARVE_LIMIT);
                        w_stall_nx  = 1'b1;
                    end else begin
                        w_starve_nx = r_starve + STV_W'(1);
                    end
                end else begin
                    w_starve_nx = r_starve;
                end
            end
            default: begin
                w_state_nx = ST_INIT;
            end
        endcase
    end

    // Registered write port, handshake and status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_starve    <= '0;
            r_wb_stall  <= 1'b1;
            r_dbg_ack   <= 1'b0;
            r_rf_wena   <= 1'b0;
            r_rf_waddr  <= '0;
            r_rf_wdata  <= '0;
            r_init_done <= 1'b0;
        end else begin
            r_starve    <= w_starve_nx;
            r_wb_stall  <= w_stall_nx;
            r_dbg_ack   <= (w_gnt == GNT_DBG);
            r_init_done <= (w_state_nx == ST_RUN);
            case (w_gnt)
                GNT_INIT: begin
                    r_rf_wena  <= 1'b1;
                    r_rf_waddr <= w_init_addr;
                    r_rf_wdata <= INIT_VALUE;
                end
                GNT_WB: begin
                    r_rf_wena  <= 1'b1;
                    r_rf_waddr <= wb_waddr;
                    r_rf_wdata <= wb_wdata;
                end
                GNT_DBG: begin
                    r_rf_wena  <= 1'b1;
                    r_rf_waddr <= dbg_waddr;
                    r_rf_wdata <= dbg_wdata;
                end
                default: begin
                    r_rf_wena  <= 1'b0;
                    r_rf_waddr <= r_rf_waddr;
                    r_rf_wdata <= r_rf_wdata;
                end
            endcase
        end
    end

    assign wb_stall  = r_wb_stall;
    assign dbg_ack   = r_dbg_ack;
    assign rf_wena   = r_rf_wena;
    assign rf_waddr  = r_rf_waddr;
    assign rf_wdata  = r_rf_wdata;
    assign init_done = r_init_done;

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Self-checking bench for regfile_wr_arbiter: directed scenarios plus a randomized
// phase, all compared cycle by cycle against a behavioural model of the port rules.
module tb_regfile_wr_arbiter;

    localparam logic [63:0] INIT_VAL = 64'd0;

    logic        clk;
    logic        rst;
    logic        clr_req;
    logic        wb_wena;
    logic [4:0]  wb_waddr;
    logic [63:0] wb_wdata;
    logic        wb_stall;
    logic        dbg_req;
    logic [4:0]  dbg_waddr;
    logic [63:0] dbg_wdata;
    logic        dbg_ack;
    logic        rf_wena;
    logic [4:0]  rf_waddr;
    logic [63:0] rf_wdata;
    logic        init_done;

    int n_vec  = 0;
    int n_fail = 0;

    // Reference model state
    bit          m_init;
    int          m_idx;
    int          m_starve;
    bit          m_stall;
    bit          m_ack;
    bit          m_wena;
    bit          m_done;
    logic [4:0]  m_addr;
    logic [63:0] m_data;

    regfile_wr_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .clr_req   (clr_req),
        .wb_wena   (wb_wena),
        .wb_waddr  (wb_waddr),
        .wb_wdata  (wb_wdata),
        .wb_stall  (wb_stall),
        .dbg_req   (dbg_req),
        .dbg_waddr (dbg_waddr),
        .dbg_wdata (dbg_wdata),
        .dbg_ack   (dbg_ack),
        .rf_wena   (rf_wena),
        .rf_waddr  (rf_waddr),
        .rf_wdata  (rf_wdata),
        .init_done (init_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic compare_all(input string tag);
        check({tag, ".rf_wena"},   64'(rf_wena),   64'(m_wena));
        check({tag, ".rf_waddr"},  64'(rf_waddr),  64'(m_addr));
        check({tag, ".rf_wdata"},  rf_wdata,       m_data);
        check({tag, ".dbg_ack"},   64'(dbg_ack),   64'(m_ack));
        check({tag, ".wb_stall"},  64'(wb_stall),  64'(m_stall));
        check({tag, ".init_done"}, 64'(init_done), 64'(m_done));
    endtask

    // One clock: model decides what must happen at the edge from this cycle's inputs.
    task automatic tick(input string tag);
        bit cons;
        bit wb;
        cons = 1'b0;
        wb   = 1'b0;
        if (m_init) begin
            m_wena = 1'b1;
            m_addr = m_idx[4:0];
            m_data = INIT_VAL;
            m_ack  = 1'b0;
            if (m_idx == 31) begin
                m_init  = 1'b0;
                m_done  = 1'b1;
                m_stall = 1'b0;
            end
            m_idx++;
        end else if (clr_req) begin
            m_init   = 1'b1;
            m_idx    = 0;
            m_done   = 1'b0;
            m_stall  = 1'b1;
            m_starve = 0;
            m_wena   = 1'b0;
            m_ack    = 1'b0;
        end else begin
            cons = dbg_req && (m_stall || (!wb_wena && !m_ack));
            wb   = !cons && wb_wena && !m_stall;
            if (cons) begin
                m_wena = 1'b1; m_addr = dbg_waddr; m_data = dbg_wdata;
                m_starve = 0;  m_stall = 1'b0;
            end else if (wb) begin
                m_wena = 1'b1; m_addr = wb_waddr; m_data = wb_wdata;
            end else begin
                m_wena = 1'b0;
            end
            if (!cons) begin
                if (!dbg_req) begin
                    m_starve = 0;
                end else if (!m_ack) begin
                    m_starve++;
                    if (m_starve >= 4) m_stall = 1'b1;
                end
            end
            m_ack = cons;
        end
        @(posedge clk);
        #1;
        compare_all(tag);
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1;
        #1;
        m_init = 1'b1; m_idx = 0; m_starve = 0; m_stall = 1'b1; m_ack = 1'b0;
        m_wena = 1'b0; m_addr = 5'd0; m_data = 64'd0; m_done = 1'b0;
        compare_all(tag);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        bit pre_ack;
        bit pre_stall;
        clr_req = 1'b0; wb_wena = 1'b0; wb_waddr = 5'd0; wb_wdata = 64'd0;
        dbg_req = 1'b0; dbg_waddr = 5'd0; dbg_wdata = 64'd0;

        // 1: power-on sweep
        do_reset("reset");
        for (int i = 0; i < 32; i++) begin
            wb_wena = 1'b1; wb_waddr = 5'd3; dbg_req = 1'b0;
            tick("init");
        end
        check("init.done_at_32", 64'(init_done), 64'd1);
        wb_wena = 1'b0;
        tick("init_end");
        check("init.wena_after", 64'(rf_wena), 64'd0);

        // 2: writeback wins a same-cycle collision
        wb_wena = 1'b1; wb_waddr = 5'd5; wb_wdata = 64'hAA;
        dbg_req = 1'b1; dbg_waddr = 5'd7; dbg_wdata = 64'h1234;
        tick("t2a");
        check("t2.wb_addr", 64'(rf_waddr), 64'd5);
        check("t2.no_ack", 64'(dbg_ack), 64'd0);
        wb_wena = 1'b0;
        tick("t2b");
        check("t2.dbg_addr", 64'(rf_waddr), 64'd7);
        check("t2.ack", 64'(dbg_ack), 64'd1);
        dbg_req = 1'b0;
        tick("t2c");

        // 3+4: starvation guard with writeback held busy, request held through ack
        wb_wena = 1'b1; wb_waddr = 5'd1; wb_wdata = 64'd1001;
        dbg_req = 1'b1; dbg_waddr = 5'd9; dbg_wdata = 64'h55;
        for (int k = 0; k < 4; k++) begin
            tick("t3_deny");
            wb_waddr = wb_waddr + 5'd1;
            wb_wdata = wb_wdata + 64'd1;
        end
        check("t3.stall_set", 64'(wb_stall), 64'd1);
        tick("t3_grant");
        check("t3.dbg_addr", 64'(rf_waddr), 64'd9);
        check("t3.dbg_data", rf_wdata, 64'h55);
        check("t3.stall_drop", 64'(wb_stall), 64'd0);
        tick("t3_held_wb");
        check("t3.held_addr", 64'(rf_waddr), 64'd5);
        check("t3.held_data", rf_wdata, 64'd1005);
        check("t4.no_dup_ack", 64'(dbg_ack), 64'd0);
        wb_wena = 1'b0;
        dbg_req = 1'b0;
        tick("t3_idle");
        dbg_req = 1'b1; dbg_waddr = 5'd12; dbg_wdata = 64'h77;
        tick("t4_grant");
        tick("t4_ackcyc");
        check("t4.no_dup_write", 64'(rf_wena), 64'd0);
        dbg_req = 1'b0;
        tick("t4_idle");

        // 5: clear with a pending console request
        dbg_req = 1'b1; dbg_waddr = 5'd3; dbg_wdata = 64'hC0FFEE;
        clr_req = 1'b1;
        tick("t5_clr");
        check("t5.clr_no_write", 64'(rf_wena), 64'd0);
        clr_req = 1'b0;
        for (int i = 0; i < 32; i++) begin
            clr_req = (i == 5) ? 1'b1 : 1'b0;
            tick("t5_init");
        end
        clr_req = 1'b0;
        tick("t5_served");
        check("t5.dbg_after_init", 64'(rf_waddr), 64'd3);
        check("t5.ack_after_init", 64'(dbg_ack), 64'd1);
        dbg_req = 1'b0;
        tick("t5_idle");

        // 6: async reset mid-sweep and during a console ack cycle
        do_reset("t6_rst0");
        for (int i = 0; i < 12; i++) tick("t6_part");
        do_reset("t6_rst_mid");
        tick("t6_restart");
        check("t6.restart_addr0", 64'(rf_waddr), 64'd0);
        for (int i = 0; i < 31; i++) tick("t6_init");
        dbg_req = 1'b1; dbg_waddr = 5'd4; dbg_wdata = 64'hBEEF;
        tick("t6_grant");
        dbg_req = 1'b0;
        do_reset("t6_rst_ack");
        for (int i = 0; i < 32; i++) tick("t6_init2");

        // Randomized traffic with protocol-compliant requesters
        for (int i = 0; i < 600; i++) begin
            pre_ack   = m_ack;
            pre_stall = m_stall;
            tick("rand");
            if (dbg_req && pre_ack) dbg_req = 1'b0;
            if (!dbg_req && ($urandom_range(2, 0) == 0)) begin
                dbg_req   = 1'b1;
                dbg_waddr = 5'($urandom);
                dbg_wdata = {$urandom, $urandom};
            end
            if (!(wb_wena && pre_stall)) begin
                wb_wena  = ($urandom_range(3, 0) != 0);
                wb_waddr = 5'($urandom);
                wb_wdata = {$urandom, $urandom};
            end
            clr_req = ($urandom_range(79, 0) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
